// File: rtl/bram_bank_loader.sv
// bram_bank_loader: scatters a valid/ready word stream round-robin across
// NUM_BANK RAM write ports and pulses o_done once the last write is issued.
`timescale 1ns/1ps

module bram_bank_loader #(
   parameter int unsigned NUM_BANK = 16,
   parameter int unsigned DW       = 128,
   parameter int unsigned AW       = 9,
   parameter int unsigned DEPTH    = 512
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [AW-1:0]       i_base_addr,
   input  logic [AW:0]         i_words_per_bank,
   input  logic                i_valid,
   input  logic [DW-1:0]       i_data,
   output logic                o_ready,
   output logic [NUM_BANK-1:0] o_ena,
   output logic [NUM_BANK-1:0] o_wea,
   output logic [AW-1:0]       o_addra,
   output logic [DW-1:0]       o_dia,
   output logic                o_busy,
   output logic                o_done
);

   localparam int unsigned BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;

   logic [AW-1:0]       base_q, base_d;
   logic [CW-1:0]       wpb_q, wpb_d;
   logic [BW-1:0]       bank_cnt_q, bank_cnt_d;
   logic [CW-1:0]       off_cnt_q, off_cnt_d;
   logic [NUM_BANK-1:0] ena_q, ena_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DW-1:0]       dia_q, dia_d;

   logic                ready_c;
   logic                accept_c;
   logic                last_c;
   logic                start_c;
   logic [AW-1:0]       tgt_addr_c;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort always wins and is ignored only in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_c) begin
               state_d = (i_words_per_bank == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (i_abort) begin
               state_d = S_IDLE;
            end else if (accept_c && last_c) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_d = i_abort ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake and status decode from the state register
   always_comb begin
      ready_c  = (state_q == S_LOAD) && !i_abort;
      accept_c = ready_c && i_valid;
      start_c  = (state_q == S_IDLE) && i_start && !i_abort;
      last_c   = (bank_cnt_q == BW'(NUM_BANK - 1)) &&
                 (off_cnt_q == (wpb_q - CW'(1)));
      o_ready  = ready_c;
      o_busy   = (state_q != S_IDLE);
      o_done   = (state_q == S_DONE);
   end

   // Target address of the word being accepted; wraps modulo DEPTH
   always_comb begin
      tgt_addr_c = AW'((32'(base_q) + 32'(off_cnt_q)) % DEPTH);
   end

   // Parameter latch, round-robin counters and write-port payload
   always_comb begin
      base_d     = base_q;
      wpb_d      = wpb_q;
      bank_cnt_d = bank_cnt_q;
      off_cnt_d  = off_cnt_q;
      ena_d      = '0;
      addr_d     = addr_q;
      dia_d      = dia_q;

      if (start_c) begin
         base_d     = i_base_addr;
         wpb_d      = i_words_per_bank;
         bank_cnt_d = '0;
         off_cnt_d  = '0;
      end

      if (accept_c) begin
         ena_d      = NUM_BANK'(1) << bank_cnt_q;
         addr_d     = tgt_addr_c;
         dia_d      = i_data;
         bank_cnt_d = bank_cnt_q + BW'(1);
         if (bank_cnt_q == BW'(NUM_BANK - 1)) begin
            bank_cnt_d = '0;
            off_cnt_d  = off_cnt_q + CW'(1);
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_q     <= '0;
         wpb_q      <= '0;
         bank_cnt_q <= '0;
         off_cnt_q  <= '0;
         ena_q      <= '0;
         addr_q     <= '0;
         dia_q      <= '0;
      end else begin
         base_q     <= base_d;
         wpb_q      <= wpb_d;
         bank_cnt_q <= bank_cnt_d;
         off_cnt_q  <= off_cnt_d;
         ena_q      <= ena_d;
         addr_q     <= addr_d;
         dia_q      <= dia_d;
      end
   end

   assign o_ena   = ena_q;
   assign o_wea   = ena_q;
   assign o_addra = addr_q;
   assign o_dia   = dia_q;

endmodule

// File: tb/tb_bram_bank_loader.sv
// Scoreboard bench for bram_bank_loader: accepted words push expected bank
// writes; a negedge monitor pops and compares every write the DUT issues.
`timescale 1ns/1ps

module tb_bram_bank_loader;

   localparam int unsigned NB = 16;
   localparam int unsigned DW = 128;
   localparam int unsigned AW = 9;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_start;
   logic          i_abort;
   logic [AW-1:0] i_base_addr;
   logic [AW:0]   i_words_per_bank;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_ready;
   logic [NB-1:0] o_ena;
   logic [NB-1:0] o_wea;
   logic [AW-1:0] o_addra;
   logic [DW-1:0] o_dia;
   logic          o_busy;
   logic          o_done;

   typedef struct packed {
      logic [NB-1:0] ena;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           mon_e;
   logic [DW-1:0] mem [0:NB-1][0:511];
   int            n_pass  = 0;
   int            n_total = 0;
   int            n_wr    = 0;
   int            n_done  = 0;
   int            w0;
   int            d0;

   always #5 clk = ~clk;

   bram_bank_loader #(
      .NUM_BANK(NB), .DW(DW), .AW(AW), .DEPTH(512)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .i_base_addr      (i_base_addr),
      .i_words_per_bank (i_words_per_bank),
      .i_valid          (i_valid),
      .i_data           (i_data),
      .o_ready          (o_ready),
      .o_ena            (o_ena),
      .o_wea            (o_wea),
      .o_addra          (o_addra),
      .o_dia            (o_dia),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: every issued write must match the head of the scoreboard
   always @(negedge clk) begin
      if (rstn) begin
         if (o_done) n_done++;
         if (o_ena != '0) begin
            n_wr++;
            chk("wea_eq_ena", 128'(o_wea), 128'(o_ena));
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 128'(o_ena), 128'(0));
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_bank", 128'(o_ena), 128'(mon_e.ena));
               chk("wr_addr", 128'(o_addra), 128'(mon_e.addr));
               chk("wr_data", o_dia, mon_e.data);
            end
            for (int b = 0; b < int'(NB); b++) begin
               if (o_ena[b]) mem[b][o_addra] = o_dia;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] wpb);
      i_base_addr      = base;
      i_words_per_bank = wpb;
      i_start          = 1'b1;
      tick();
      i_start          = 1'b0;
   endtask

   // Offer words k0..k0+n-1; each acceptance pushes its expected write
   task automatic send_words(input logic [AW-1:0] base, input int k0, input int n,
                             input logic [DW-1:0] dbase, input bit stall);
      int k;
      int guard;
      k     = k0;
      guard = 0;
      while (k < k0 + n && guard < 2000) begin
         i_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         i_data  = dbase + 128'(k);
         @(negedge clk);
         if (i_valid && o_ready) begin
            exp_q.push_back('{ena:  NB'(1) << (k % 16),
                              addr: AW'((32'(base) + 32'(k / 16)) % 512),
                              data: i_data});
            k++;
         end
         tick();
         guard++;
      end
      i_valid = 1'b0;
      if (guard >= 2000) chk("send_timeout", 128'(k), 128'(k0 + n));
   endtask

   // Entered one cycle after the last acceptance: FLUSH, DONE, IDLE
   task automatic check_tail(input string nm);
      @(negedge clk);
      chk({nm, "_flush_busy"}, 128'(o_busy), 128'(1));
      chk({nm, "_flush_done"}, 128'(o_done), 128'(0));
      chk({nm, "_flush_ready"}, 128'(o_ready), 128'(0));
      tick();
      @(negedge clk);
      chk({nm, "_done_pulse"}, 128'(o_done), 128'(1));
      tick();
      @(negedge clk);
      chk({nm, "_idle_busy"}, 128'(o_busy), 128'(0));
      chk({nm, "_idle_done"}, 128'(o_done), 128'(0));
      tick();
   endtask

   initial begin
      #200us;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_base_addr = '0;
      i_words_per_bank = '0; i_valid = 1'b0; i_data = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ena", 128'(o_ena), 128'(0));
      chk("rst_busy", 128'(o_busy), 128'(0));
      chk("rst_addr", 128'(o_addra), 128'(0));
      tick();
      rstn = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("post_rst_ena", 128'(o_ena), 128'(0));
      chk("post_rst_dia", o_dia, 128'(0));
      chk("post_rst_ready", 128'(o_ready), 128'(0));
      chk("post_rst_busy", 128'(o_busy), 128'(0));
      chk("post_rst_done", 128'(o_done), 128'(0));
      tick();

      // Basic load: base 0, 2 words per bank, data = k
      start_load(9'd0, 10'd2);
      chk("basic_ready_s1", 128'(o_ready), 128'(1));
      send_words(9'd0, 0, 32, 128'h0, 1'b0);
      check_tail("basic");
      chk("basic_mem_b0a0", mem[0][0], 128'd0);
      chk("basic_mem_b15a0", mem[15][0], 128'd15);
      chk("basic_mem_b0a1", mem[0][1], 128'd16);
      chk("basic_mem_b15a1", mem[15][1], 128'd31);
      chk("basic_nwr", 128'(n_wr), 128'(32));
      chk("basic_ndone", 128'(n_done), 128'(1));

      // Stalled stream, one word per bank
      w0 = n_wr; d0 = n_done;
      start_load(9'd7, 10'd1);
      send_words(9'd7, 0, 16, 128'h5000, 1'b1);
      check_tail("stall");
      chk("stall_nwr", 128'(n_wr - w0), 128'(16));
      chk("stall_ndone", 128'(n_done - d0), 128'(1));
      chk("stall_mem_b9", mem[9][7], 128'h5009);

      // Address wrap past DEPTH-1
      start_load(9'd510, 10'd4);
      send_words(9'd510, 0, 64, 128'hA000, 1'b0);
      check_tail("wrap");
      chk("wrap_mem_b0a510", mem[0][510], 128'hA000);
      chk("wrap_mem_b3a0", mem[3][0], 128'hA023);
      chk("wrap_mem_b15a1", mem[15][1], 128'hA03F);

      // Zero-count start goes straight to DONE
      w0 = n_wr; d0 = n_done;
      start_load(9'd33, 10'd0);
      @(negedge clk);
      chk("zero_done", 128'(o_done), 128'(1));
      chk("zero_ena", 128'(o_ena), 128'(0));
      tick();
      @(negedge clk);
      chk("zero_done_end", 128'(o_done), 128'(0));
      chk("zero_busy_end", 128'(o_busy), 128'(0));
      tick();
      chk("zero_nwr", 128'(n_wr - w0), 128'(0));
      chk("zero_ndone", 128'(n_done - d0), 128'(1));

      // Start pulse during LOAD is ignored
      start_load(9'd0, 10'd1);
      send_words(9'd0, 0, 3, 128'hB000, 1'b0);
      i_base_addr = 9'd300; i_words_per_bank = 10'd5; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      send_words(9'd0, 3, 13, 128'hB000, 1'b0);
      check_tail("ignstart");

      // Abort after 5 accepted words
      w0 = n_wr; d0 = n_done;
      start_load(9'd100, 10'd2);
      send_words(9'd100, 0, 5, 128'hC000, 1'b0);
      i_valid = 1'b1; i_data = 128'hDEAD; i_abort = 1'b1;
      @(negedge clk);
      chk("abort_ready", 128'(o_ready), 128'(0));
      chk("abort_busy", 128'(o_busy), 128'(1));
      tick();
      i_abort = 1'b0; i_valid = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy", 128'(o_busy), 128'(0));
      chk("abort_idle_ena", 128'(o_ena), 128'(0));
      repeat (3) tick();
      chk("abort_nwr", 128'(n_wr - w0), 128'(5));
      chk("abort_ndone", 128'(n_done - d0), 128'(0));

      // A full load after the abort completes normally
      start_load(9'd20, 10'd1);
      send_words(9'd20, 0, 16, 128'hE000, 1'b0);
      check_tail("post_abort");
      chk("post_abort_ndone", 128'(n_done - d0), 128'(1));
      chk("post_abort_mem", mem[4][20], 128'hE004);

      repeat (3) tick();
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
